// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM port-B arbiter.
package bram_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Channel tag width; never narrower than one bit.
    function automatic int tag_w(input int num_ch);
        return (num_ch > 1) ? clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_pick.sv
// Round-robin picker: first requester strictly after 'last' in cyclic order,
// wrapping back to 'last' itself when it is the only requester.
module rr_pick
    import bram_arb_pkg::*;
#(
    parameter int N    = 2,
    parameter int CH_W = tag_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [CH_W-1:0] last,
    output logic [N-1:0]    gnt,
    output logic [CH_W-1:0] idx,
    output logic            any
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] req_rot;
    int             sel;
    int             pos;

    always_comb begin
        req_dbl = {req, req};
        // Rotating the doubled vector puts channel last+1 at bit 0.
        req_rot = req_dbl >> (int'(last) + 1);
        any     = |req;
        sel     = 0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                sel = j;
            end
        end
        pos = (int'(last) + 1 + sel) % N;
        idx = any ? CH_W'(pos) : '0;
        gnt = '0;
        for (int k = 0; k < N; k++) begin
            gnt[k] = any && (pos == k);
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// N-channel round-robin arbiter for one BRAM port with registered drive
// and tagged read-data return.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 64,
    parameter int WE_W      = DATA_W / 8,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                       trn_clk,
    input  logic                       trn_reset_n,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*WE_W-1:0]     ch_we,
    input  logic [NUM_CH*DATA_W-1:0]   ch_din,
    output logic [NUM_CH-1:0]          ch_gnt,
    output logic [NUM_CH-1:0]          ch_rvalid,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic [ADDR_W-1:0]          bram_addr,
    output logic [WE_W-1:0]            bram_we,
    output logic [DATA_W-1:0]          bram_din,
    input  logic [DATA_W-1:0]          bram_dout
);

    // state   | meaning
    // IDLE    | no owner, no grant
    // BUSY    | owner = last_owner_q, burst_cnt_q = accesses after its first
    localparam int              CH_W       = tag_w(NUM_CH);
    localparam int              BC_W       = clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0] BURST_LAST = BC_W'(MAX_BURST - 1);

    if (NUM_CH < 2 || (DATA_W % 8) != 0) begin : g_param_check
        $error("bram_port_arbiter: NUM_CH must be >= 2 and DATA_W a multiple of 8");
    end

    arb_state_t                 state_q, state_d;
    logic [CH_W-1:0]            last_owner_q, last_owner_d;
    logic [BC_W-1:0]            burst_cnt_q, burst_cnt_d;
    logic [ADDR_W-1:0]          bram_addr_q, bram_addr_d;
    logic [WE_W-1:0]            bram_we_q, bram_we_d;
    logic [DATA_W-1:0]          bram_din_q, bram_din_d;
    logic [RD_LAT:0]            pipe_vld_q, pipe_vld_d;
    logic [RD_LAT:0][CH_W-1:0]  pipe_tag_q, pipe_tag_d;
    logic [NUM_CH-1:0]          ch_rvalid_q, ch_rvalid_d;
    logic [DATA_W-1:0]          ch_rdata_q, ch_rdata_d;

    logic [NUM_CH-1:0]          pick_gnt;
    logic [CH_W-1:0]            pick_idx;
    logic                       pick_any;
    logic                       keep_owner;
    logic [NUM_CH-1:0]          gnt;
    logic                       acc;
    logic [CH_W-1:0]            acc_ch;
    logic [ADDR_W-1:0]          sel_addr;
    logic [WE_W-1:0]            sel_we;
    logic [DATA_W-1:0]          sel_din;
    logic                       rd_acc;

    rr_pick #(
        .N    (NUM_CH),
        .CH_W (CH_W)
    ) u_pick (
        .req  (ch_req),
        .last (last_owner_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Grant is a function of ch_req and registered state only.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        gnt          = pick_gnt;
        acc_ch       = pick_idx;
        keep_owner   = (state_q == ST_BUSY) && ch_req[last_owner_q]
                       && (burst_cnt_q < BURST_LAST);

        case (state_q)
            ST_IDLE: if (pick_any)  state_d = ST_BUSY;
            ST_BUSY: if (!pick_any) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (keep_owner) begin
            acc_ch      = last_owner_q;
            burst_cnt_d = burst_cnt_q + 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
                gnt[k] = (last_owner_q == CH_W'(k));
            end
        end else if (pick_any) begin
            last_owner_d = pick_idx;
            burst_cnt_d  = '0;
        end

        acc = |gnt;
    end

    always_comb begin
        sel_addr = '0;
        sel_we   = '0;
        sel_din  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (acc_ch == CH_W'(k)) begin
                sel_addr = ch_addr[k*ADDR_W +: ADDR_W];
                sel_we   = ch_we[k*WE_W +: WE_W];
                sel_din  = ch_din[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        bram_we_d   = '0;
        if (acc) begin
            bram_addr_d = sel_addr;
            bram_we_d   = sel_we;
            bram_din_d  = sel_din;
        end

        rd_acc     = acc && (sel_we == '0);
        pipe_vld_d = {pipe_vld_q[RD_LAT-1:0], rd_acc};
        pipe_tag_d = {pipe_tag_q[RD_LAT-1:0], acc_ch};

        // Last pipe stage lines up with valid bram_dout.
        ch_rvalid_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_rvalid_d[k] = pipe_vld_q[RD_LAT] && (pipe_tag_q[RD_LAT] == CH_W'(k));
        end
        ch_rdata_d = pipe_vld_q[RD_LAT] ? bram_dout : ch_rdata_q;
    end

    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state_q      <= ST_IDLE;
            last_owner_q <= CH_W'(NUM_CH - 1);
            burst_cnt_q  <= '0;
            bram_addr_q  <= '0;
            bram_we_q    <= '0;
            bram_din_q   <= '0;
            pipe_vld_q   <= '0;
            pipe_tag_q   <= '0;
            ch_rvalid_q  <= '0;
            ch_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            bram_addr_q  <= bram_addr_d;
            bram_we_q    <= bram_we_d;
            bram_din_q   <= bram_din_d;
            pipe_vld_q   <= pipe_vld_d;
            pipe_tag_q   <= pipe_tag_d;
            ch_rvalid_q  <= ch_rvalid_d;
            ch_rdata_q   <= ch_rdata_d;
        end
    end

    assign ch_gnt    = gnt;
    assign bram_addr = bram_addr_q;
    assign bram_we   = bram_we_q;
    assign bram_din  = bram_din_q;
    assign ch_rvalid = ch_rvalid_q;
    assign ch_rdata  = ch_rdata_q;

endmodule
